ps2_tx_scheduler: RTL

Sequences and shares the single `ps2_send` byte transmitter between several requesters, such as debounced buttons, a scancode generator and a host-command echo. It grants requesters round-robin and launches one byte at a time. It tracks the transmitter's `busy` handshake and enforces an inter-byte gap so the PS/2 host sees well-spaced frames. It sits between the requester logic and `ps2_send` in the top level.

---
 rtl/ps2_sched_pkg.sv | 17 +
 rtl/ps2_rr_arbiter.sv | 40 ++++
 rtl/ps2_tx_scheduler.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ps2_sched_pkg.sv
// Shared constants and state encoding for the PS/2 transmit scheduler.
// The optional launch timeout is enabled by defining PS2_SCHED_TIMEOUT_EN.
package ps2_sched_pkg;

  localparam int PS2_SCHED_MAX_NREQ          = 8;
  localparam int PS2_SCHED_GAP_DEFAULT       = 12500;   // 500 us at 25 MHz
  localparam int PS2_SCHED_TIMEOUT_DEFAULT   = 250000;  // 10 ms at 25 MHz

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_SENDING   = 3'd3,
    S_GAP       = 3'd4
  } sched_state_e;

endpackage

// File: rtl/ps2_rr_arbiter.sv
// Combinational round-robin picker: first requester found searching upward
// from last_grant+1, wrapping modulo NREQ.
module ps2_rr_arbiter
  import ps2_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDXW = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last_grant,
  output logic [NREQ-1:0] pick,
  output logic [IDXW-1:0] pick_idx,
  output logic            any
);

  logic found;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    any      = |req;
    // Upper half of the rotation first, then wrap to the lower half.
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i > int'(last_grant))) begin
        found    = 1'b1;
        pick[i]  = 1'b1;
        pick_idx = IDXW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i <= int'(last_grant))) begin
        found    = 1'b1;
        pick[i]  = 1'b1;
        pick_idx = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/ps2_tx_scheduler.sv
// Shares one ps2_send transmitter between NREQ requesters with round-robin
// grants and an inter-frame gap. Define PS2_SCHED_TIMEOUT_EN for the launch timeout.
module ps2_tx_scheduler
  import ps2_sched_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int GAP_CYCLES     = PS2_SCHED_GAP_DEFAULT,
  parameter int TIMEOUT_CYCLES = PS2_SCHED_TIMEOUT_DEFAULT
) (
  input  logic              clk_25mhz,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] data,
  output logic [NREQ-1:0]   grant,
  output logic              tx_req,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              active,
  output logic              timeout_err
);

  localparam int IDXW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  if (NREQ < 1 || NREQ > PS2_SCHED_MAX_NREQ || GAP_CYCLES < 0 || TIMEOUT_CYCLES < 0)
  begin : g_bad_param
    $error("ps2_tx_scheduler: parameter out of range");
  end

  sched_state_e     state_q, state_d;
  logic [IDXW-1:0]  last_grant_q, last_grant_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [NREQ-1:0]  pick;
  logic [IDXW-1:0]  pick_idx;
  logic             any;
  logic             to_fire;

  ps2_rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
    .req        (req),
    .last_grant (last_grant_q),
    .pick       (pick),
    .pick_idx   (pick_idx),
    .any        (any)
  );

`ifdef PS2_SCHED_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_err_q, to_err_d;

  // Counter only runs while waiting for busy; any other state clears it.
  always_comb begin
    to_cnt_d = '0;
    to_err_d = to_err_q;
    to_fire  = 1'b0;
    if (state_q == S_WAIT_BUSY && !tx_busy) begin
      if (int'(to_cnt_q) + 1 >= TIMEOUT_CYCLES) begin
        to_fire  = 1'b1;
        to_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err = to_err_q;
`else
  assign to_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    tx_data_d    = tx_data_q;
    gap_cnt_d    = gap_cnt_q;
    unique case (state_q)
      // A frame already on the wire (e.g. after reset) blocks acceptance.
      S_IDLE: begin
        if (!tx_busy && any) begin
          last_grant_d = pick_idx;
          for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) tx_data_d = data[8*i +: 8];
          end
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (tx_busy)      state_d = S_SENDING;
        else if (to_fire) state_d = S_IDLE;
      end
      S_SENDING: begin
        if (!tx_busy) begin
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_W'(GAP_CYCLES);
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) state_d = S_IDLE;
        else                        gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= IDXW'(NREQ - 1);
      tx_data_q    <= 8'h00;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      tx_data_q    <= tx_data_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  // last_grant_q already names the winner during LAUNCH.
  always_comb begin
    grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = (state_q == S_LAUNCH) && (last_grant_q == IDXW'(i));
    end
  end

  assign tx_req  = (state_q == S_LAUNCH);
  assign active  = (state_q != S_IDLE);
  assign tx_data = tx_data_q;

endmodule
